// File: rtl/led_frame_sequencer.sv
// LED frame sequencer: walks the Wishbone fetcher through one frame, double-buffers the host
// buffer selection and inserts an inter-frame gap. Optional fetch watchdog: LED_SEQ_TIMEOUT_EN.
module led_frame_sequencer #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WORDS_PER_FRAME = 11,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  host_swap_req,
    input  logic [DATA_WIDTH-1:0] host_buf_id,
    output logic [DATA_WIDTH-1:0] buf_id,
    output logic                  wb_request_first_word,
    output logic                  wb_request_next_word,
    input  logic                  wb_recieved_new_word,
    input  logic [DATA_WIDTH-1:0] wb_received_word,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  fetch_error
);

    localparam int unsigned CntW = $clog2(WORDS_PER_FRAME) + 1;
    localparam int unsigned GapW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CntW-1:0] LastWord = CntW'(WORDS_PER_FRAME - 1);
    localparam logic [GapW-1:0] LastGap  = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReqFirst,
        StWait,
        StHold,
        StReqNext,
        StGap
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] active_buf_q;
    logic [DATA_WIDTH-1:0] pending_buf_q;
    logic                  pending_vld_q;
    logic [CntW-1:0]       word_cnt_q;
    logic [GapW-1:0]       gap_cnt_q;

`ifdef LED_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WdW-1:0] LastWd = WdW'(TIMEOUT_CYCLES - 1);
    logic [WdW-1:0] wd_cnt_q;
`else
    assign fetch_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= StIdle;
            active_buf_q          <= '0;
            pending_buf_q         <= '0;
            pending_vld_q         <= 1'b0;
            word_cnt_q            <= '0;
            gap_cnt_q             <= '0;
            buf_id                <= '0;
            wb_request_first_word <= 1'b0;
            wb_request_next_word  <= 1'b0;
            word_out              <= '0;
            word_valid            <= 1'b0;
            frame_start           <= 1'b0;
            frame_done            <= 1'b0;
            busy                  <= 1'b0;
`ifdef LED_SEQ_TIMEOUT_EN
            wd_cnt_q              <= '0;
            fetch_error           <= 1'b0;
`endif
        end else begin
            frame_start           <= 1'b0;
            frame_done            <= 1'b0;
            wb_request_first_word <= 1'b0;
            wb_request_next_word  <= 1'b0;

            // A new request always lands in the pending slot; last one wins.
            if (host_swap_req) begin
                pending_buf_q <= host_buf_id;
                pending_vld_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    word_cnt_q <= '0;
                    if (pending_vld_q) begin
                        active_buf_q <= pending_buf_q;
                        buf_id       <= pending_buf_q;
                        // Keep a request arriving in this very cycle for the next boundary.
                        if (!host_swap_req) begin
                            pending_vld_q <= 1'b0;
                        end
                    end else begin
                        buf_id <= active_buf_q;
                    end
                    if (enable) begin
                        state_q               <= StReqFirst;
                        frame_start           <= 1'b1;
                        wb_request_first_word <= 1'b1;
                        busy                  <= 1'b1;
                    end
                end
                StReqFirst: begin
`ifdef LED_SEQ_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (wb_recieved_new_word) begin
                        word_out   <= wb_received_word;
                        word_valid <= 1'b1;
                        state_q    <= StHold;
                    end
`ifdef LED_SEQ_TIMEOUT_EN
                    else if (wd_cnt_q == LastWd) begin
                        fetch_error <= 1'b1;
                        word_valid  <= 1'b0;
                        gap_cnt_q   <= '0;
                        state_q     <= StGap;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                StHold: begin
                    if (word_valid && word_ready) begin
                        word_valid <= 1'b0;
                        if (word_cnt_q == LastWord) begin
                            frame_done <= 1'b1;
                            gap_cnt_q  <= '0;
                            state_q    <= StGap;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            state_q    <= StReqNext;
                        end
                    end
                end
                StReqNext: begin
`ifdef LED_SEQ_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                    wb_request_next_word <= 1'b1;
                    state_q              <= StWait;
                end
                StGap: begin
                    if (gap_cnt_q == LastGap) begin
                        gap_cnt_q <= '0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: expected words queued per frame, monitor pops on
// each accepted word. Watchdog checks are built when LED_SEQ_TIMEOUT_EN is defined.
module tb_led_frame_sequencer;

    localparam int WORDS = 11;
    localparam int GAP   = 16;
    localparam int TO    = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        host_swap_req;
    logic [31:0] host_buf_id;
    logic [31:0] buf_id;
    logic        wb_request_first_word;
    logic        wb_request_next_word;
    logic        wb_recieved_new_word;
    logic [31:0] wb_received_word;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic        fetch_error;

    led_frame_sequencer #(
        .DATA_WIDTH     (32),
        .WORDS_PER_FRAME(WORDS),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .host_swap_req        (host_swap_req),
        .host_buf_id          (host_buf_id),
        .buf_id               (buf_id),
        .wb_request_first_word(wb_request_first_word),
        .wb_request_next_word (wb_request_next_word),
        .wb_recieved_new_word (wb_recieved_new_word),
        .wb_received_word     (wb_received_word),
        .word_out             (word_out),
        .word_valid           (word_valid),
        .word_ready           (word_ready),
        .frame_start          (frame_start),
        .frame_done           (frame_done),
        .busy                 (busy),
        .fetch_error          (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_first = 0, n_next = 0, n_start = 0, n_done = 0, n_acc = 0;
    int          cyc = 0, done_cyc = 0;
    bit          have_done = 0;
    logic [31:0] start_buf = '0;
    logic [31:0] exp_q[$];
    bit          mute = 0;
    bit          inject = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Fetcher model: answers each request three cycles later with a word tagged by buffer/index.
    initial begin : fetcher
        int          cd;
        int          idx;
        logic [31:0] pend;
        cd = 0;
        idx = 0;
        pend = '0;
        wb_recieved_new_word = 1'b0;
        wb_received_word = '0;
        forever begin
            @(posedge clk);
            #2;
            wb_recieved_new_word = 1'b0;
            if (inject) begin
                wb_recieved_new_word = 1'b1;
                wb_received_word = 32'hDEAD_BEEF;
            end
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    wb_recieved_new_word = 1'b1;
                    wb_received_word = pend;
                end
            end
            if (!mute && (wb_request_first_word || wb_request_next_word)) begin
                idx = wb_request_first_word ? 0 : idx + 1;
                pend = {buf_id[15:0], 8'hA5, idx[7:0]};
                cd = 3;
            end
        end
    end

    // Monitor: event counters, scoreboard pops on handshake, stall stability.
    initial begin : monitor
        bit          stall_prev;
        logic [31:0] stall_word;
        logic [31:0] exp;
        stall_prev = 0;
        stall_word = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wb_request_first_word) n_first++;
            if (wb_request_next_word) n_next++;
            if (frame_start) begin
                n_start++;
                start_buf = buf_id;
                if (have_done) check("gap_len", {31'b0, (cyc - done_cyc) >= GAP + 1}, 32'd1);
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                have_done = 1;
            end
            if (word_valid && word_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h with no word expected", word_out);
                end else begin
                    exp = exp_q.pop_front();
                    check("word", word_out, exp);
                    check("buf_id_stable", buf_id, start_buf);
                end
            end
            if (word_valid && !word_ready) begin
                if (stall_prev) check("stall_hold", word_out, stall_word);
                check("no_next_in_stall", {31'b0, wb_request_next_word}, 32'd0);
                stall_prev = 1;
                stall_word = word_out;
            end else begin
                stall_prev = 0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (busy && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (busy) bound_fail(name);
    endtask

    // mode: 0 plain, 1 stall on word 4, 2 swaps 3 then 5 mid-frame, 3 swap 9 at frame start
    task automatic run_frame(input logic [31:0] exp_bid, input int mode);
        int s_start, s_done, s_first, s_next, s_acc, g;
        wait_idle("idle_before_frame");
        s_start = n_start;
        s_done = n_done;
        s_first = n_first;
        s_next = n_next;
        s_acc = n_acc;
        for (int i = 0; i < WORDS; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            exp_q.push_back({exp_bid[15:0], 8'hA5, ib});
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        if (mode == 3) begin
            host_buf_id = 32'd9;
            host_swap_req = 1'b1;
        end
        @(posedge clk);
        #1;
        host_swap_req = 1'b0;
        enable = 1'b0;
        if (mode == 1) begin
            g = 0;
            while ((n_acc - s_acc) != 4 && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            word_ready = 1'b0;
            g = 0;
            while (!word_valid && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (!word_valid) bound_fail("stall_word_valid");
            repeat (5) @(posedge clk);
            #1;
            word_ready = 1'b1;
        end
        if (mode == 2) begin
            g = 0;
            while ((n_acc - s_acc) != 2 && g < 2000) begin
                @(posedge clk);
                #1;
                g++;
            end
            host_buf_id = 32'd3;
            host_swap_req = 1'b1;
            @(posedge clk);
            #1;
            host_swap_req = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            host_buf_id = 32'd5;
            host_swap_req = 1'b1;
            @(posedge clk);
            #1;
            host_swap_req = 1'b0;
        end
        g = 0;
        while (n_done == s_done && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (n_done == s_done) bound_fail("frame_done_wait");
        check("start_count", 32'(n_start - s_start), 32'd1);
        check("done_count", 32'(n_done - s_done), 32'd1);
        check("first_req_count", 32'(n_first - s_first), 32'd1);
        check("next_req_count", 32'(n_next - s_next), 32'(WORDS - 1));
        check("accepted_count", 32'(n_acc - s_acc), 32'(WORDS));
        check("frame_buf_id", start_buf, exp_bid);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin : stim
        int g, t0, s_done, s_acc;
        reset = 1'b1;
        enable = 1'b0;
        host_swap_req = 1'b0;
        host_buf_id = '0;
        word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_buf_id", buf_id, 32'd0);
        check("rst_word_valid", {31'b0, word_valid}, 32'd0);
        check("rst_word_out", word_out, 32'd0);
        check("rst_req_first", {31'b0, wb_request_first_word}, 32'd0);
        check("rst_fetch_error", {31'b0, fetch_error}, 32'd0);

        run_frame(32'd0, 0);
        run_frame(32'd0, 1);
        run_frame(32'd0, 2);
        run_frame(32'd5, 3);
        run_frame(32'd9, 0);

        // Reset during WAIT, then a stray fetcher pulse two cycles later.
        mute = 1;
        wait_idle("idle_before_reset");
        s_acc = n_acc;
        @(posedge clk);
        #1;
        enable = 1'b1;
        g = 0;
        while (!wb_request_first_word && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        inject = 1;
        @(posedge clk);
        #1;
        inject = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_word_valid", {31'b0, word_valid}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_word_out", word_out, 32'd0);
        check("post_rst_buf_id", buf_id, 32'd0);
        check("post_rst_no_accept", 32'(n_acc - s_acc), 32'd0);
        mute = 0;
        run_frame(32'd0, 0);

`ifdef LED_SEQ_TIMEOUT_EN
        mute = 1;
        wait_idle("idle_before_timeout");
        s_done = n_done;
        @(posedge clk);
        #1;
        enable = 1'b1;
        g = 0;
        while (!wb_request_first_word && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        t0 = cyc;
        enable = 1'b0;
        g = 0;
        while (!fetch_error && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!fetch_error) bound_fail("fetch_error_wait");
        check("timeout_latency", 32'(cyc - t0), 32'(TO + 1));
        check("timeout_word_valid", {31'b0, word_valid}, 32'd0);
        wait_idle("idle_after_timeout");
        check("timeout_no_done", 32'(n_done - s_done), 32'd0);
        mute = 0;
        run_frame(32'd0, 0);
        check("fetch_error_sticky", {31'b0, fetch_error}, 32'd1);
`else
        check("fetch_error_tied", {31'b0, fetch_error}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
